// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared types and constants for the PS/2 keycode receiver and the
//   downstream operator/number decoder stage.
//   - ps2_state_t : deframing FSM states
//   - scancode constants (set 2 make codes) for prefixes, control keys,
//     digits and keypad operators
//   - frame_odd_ok: odd-parity check over data byte plus parity bit
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Prefix and control codes
    localparam logic [7:0] BRK   = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;
    localparam logic [7:0] ENTER = 8'h5A;
    localparam logic [7:0] ESC   = 8'h76;

    // Top-row digit make codes
    localparam logic [7:0] KEY_0 = 8'h45;
    localparam logic [7:0] KEY_1 = 8'h16;
    localparam logic [7:0] KEY_2 = 8'h1E;
    localparam logic [7:0] KEY_3 = 8'h26;
    localparam logic [7:0] KEY_4 = 8'h25;
    localparam logic [7:0] KEY_5 = 8'h2E;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h3D;
    localparam logic [7:0] KEY_8 = 8'h3E;
    localparam logic [7:0] KEY_9 = 8'h46;

    // Keypad operators (KP_DIV arrives behind an EXT prefix)
    localparam logic [7:0] KP_PLUS  = 8'h79;
    localparam logic [7:0] KP_MINUS = 8'h7B;
    localparam logic [7:0] KP_MUL   = 8'h7C;
    localparam logic [7:0] KP_DIV   = 8'h4A;

    // Odd parity: the eight data bits plus the parity bit hold an odd
    // number of ones.
    function automatic logic frame_odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter
//   Brings the raw PS/2 lines into the clk domain and debounces ps2_clk.
//   Ports:
//     clk, rst_n  : system clock, synchronous active-low reset
//     ps2_clk     : raw PS/2 clock (asynchronous)
//     ps2_data    : raw PS/2 data (asynchronous)
//     fall        : 1-cycle pulse when the filtered clock goes 1->0
//     data_s      : synchronised ps2_data, valid alongside fall
module ps2_edge_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          flt;
    logic [CW-1:0] cnt;
    logic          accept;

    // Filtered level follows the synced clock only after FILTER_LEN
    // consecutive samples disagreeing with it; any agreeing sample restarts
    // the run, so short glitches never reach the FSM.
    assign accept = (clk_sync[1] != flt) && (cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            flt      <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
            data_s   <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            data_s   <= dat_sync[1];
            fall     <= accept && flt;
            if (clk_sync[1] == flt) begin
                cnt <= '0;
            end else if (accept) begin
                flt <= clk_sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//   PS/2 keyboard receiver: deframes 11-bit frames (start, 8 data LSB first,
//   odd parity, stop) and keeps a 4-byte history plus a make/break flag.
//   Ports:
//     clk, rst_n  : system clock, synchronous active-low reset
//     ps2_clk     : raw PS/2 clock (asynchronous input)
//     ps2_data    : raw PS/2 data (asynchronous input)
//     x[31:0]     : byte history {b3,b2,b1,b0}, b0 newest
//     flag        : 1 when the newest byte followed an F0 break prefix
//     code_valid  : 1-cycle pulse, good byte shifted into x
//     frame_err   : 1-cycle pulse, parity / stop / timeout error
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] x,
    output logic        flag,
    output logic        code_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          fall;
    logic          data_s;

    ps2_state_t    state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    sh, sh_n;
    logic          par, par_n;
    logic [TW-1:0] idle_cnt, idle_cnt_n;
    logic          good, bad;
    logic          brk_pend;

    ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_s   (data_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            sh       <= '0;
            par      <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            sh       <= sh_n;
            par      <= par_n;
            idle_cnt <= idle_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        sh_n       = sh;
        par_n      = par;
        idle_cnt_n = '0;
        good       = 1'b0;
        bad        = 1'b0;

        case (state)
            ST_IDLE: begin
                // A high data bit on a fall is line noise, not a start bit.
                if (fall && !data_s) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    sh_n      = {data_s, sh[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_n   = data_s;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_n = ST_IDLE;
                    if (data_s && frame_odd_ok(sh, par)) good = 1'b1;
                    else                                  bad  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Mid-frame watchdog: a device that stops clocking releases us back
        // to IDLE so the next start bit is not mistaken for a data bit.
        if (state != ST_IDLE && !fall) begin
            if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                state_n = ST_IDLE;
                bad     = 1'b1;
            end else begin
                idle_cnt_n = idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x          <= '0;
            flag       <= 1'b0;
            brk_pend   <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= good;
            frame_err  <= bad;
            if (good) begin
                x <= {x[23:0], sh};
                // F0 only arms the break; the following key code carries it.
                if (sh == BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    flag     <= brk_pend;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
module tb_ps2_keycode_rx;

    localparam int FL  = 8;
    localparam int TO  = 2000;
    localparam int HB  = 40;   // PS/2 half bit period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] x;
    logic        flag, code_valid, frame_err;

    ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .x          (x),
        .flag       (flag),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          good;
        logic [31:0] x;
        bit          flag;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          cv_cnt = 0;
    int          fe_cnt = 0;
    bit          run_chk = 1'b0;
    logic [31:0] cur_x = '0;
    bit          cur_flag = 1'b0;

    // Specification-level model state
    logic [31:0] mx = '0;
    bit          mflag = 1'b0;
    bit          mbrk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle compare: every pulse must match the next predicted frame
    // outcome; between pulses x/flag must hold the last accepted values.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && run_chk) begin
            checks++;
            if (code_valid && frame_err) begin
                errors++;
                $display("FAIL both_pulses cv=%b fe=%b", code_valid, frame_err);
            end else if (code_valid || frame_err) begin
                if (code_valid) cv_cnt++;
                if (frame_err)  fe_cnt++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cv=%b fe=%b", code_valid, frame_err);
                end else begin
                    e = expq.pop_front();
                    if (e.good != code_valid) begin
                        errors++;
                        $display("FAIL pulse_kind cv=%b want_good=%b", code_valid, e.good);
                    end else if (e.good && (x !== e.x || flag !== e.flag)) begin
                        errors++;
                        $display("FAIL update x=%h flag=%b want x=%h flag=%b", x, flag, e.x, e.flag);
                    end
                    if (e.good) begin
                        cur_x    = e.x;
                        cur_flag = e.flag;
                    end
                end
            end else if (x !== cur_x || flag !== cur_flag) begin
                errors++;
                $display("FAIL hold x=%h flag=%b want x=%h flag=%b", x, flag, cur_x, cur_flag);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        wait_clk(HB / 2);
        ps2_clk = 1'b0;
        wait_clk(HB);
        ps2_clk = 1'b1;
        wait_clk(HB / 2);
    endtask

    // Predict the outcome from the frame rules, then drive the 11 bits.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        logic  p;
        exp_t  e;
        p = ~(^b);
        if (bad_par) p = ~p;
        e.good = stop && (^{b, p});
        if (e.good) begin
            mx = {mx[23:0], b};
            if (b == 8'hF0) mbrk = 1'b1;
            else begin
                mflag = mbrk;
                mbrk  = 1'b0;
            end
        end
        e.x    = mx;
        e.flag = mflag;
        expq.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop);
        ps2_data = 1'b1;
        wait_clk(50);
        chk("frame_done", expq.size(), 0);
    endtask

    initial begin
        exp_t e;
        wait_clk(5);
        chk("rst_x", x, 32'h0);
        chk("rst_flag", {31'b0, flag}, 32'h0);
        chk("rst_cv", {31'b0, code_valid}, 32'h0);
        chk("rst_fe", {31'b0, frame_err}, 32'h0);
        rst_n = 1'b1;
        wait_clk(5);
        run_chk = 1'b1;

        // 1: single make code
        send_frame(8'h16, 1'b0, 1'b1);
        chk("t1_x", x, 32'h0000_0016);
        chk("t1_flag", {31'b0, flag}, 32'h0);
        chk("t1_cv_cnt", cv_cnt, 1);

        // 2: break sequence then a fresh make
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("t2_f0_flag", {31'b0, flag}, 32'h0);
        send_frame(8'h16, 1'b0, 1'b1);
        chk("t2_x", x, 32'h0016_F016);
        chk("t2_flag", {31'b0, flag}, 32'h1);
        send_frame(8'h1E, 1'b0, 1'b1);
        chk("t2_x2", x, 32'h16F0_161E);
        chk("t2_flag2", {31'b0, flag}, 32'h0);
        chk("model_x", mx, 32'h16F0_161E);

        // 3: parity error
        send_frame(8'h45, 1'b1, 1'b1);
        chk("t3_x", x, 32'h16F0_161E);
        chk("t3_fe_cnt", fe_cnt, 1);

        // 4: stop bit error, then recovery
        send_frame(8'h26, 1'b0, 1'b0);
        chk("t4_fe_cnt", fe_cnt, 2);
        chk("t4_cv_cnt", cv_cnt, 4);
        send_frame(8'h25, 1'b0, 1'b1);
        chk("t4_x", x, 32'hF016_1E25);

        // 5: start + 3 data bits, then stall past the watchdog
        e.good = 1'b0; e.x = mx; e.flag = mflag;
        expq.push_back(e);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(TO + 300);
        chk("t5_timeout", expq.size(), 0);
        chk("t5_fe_cnt", fe_cnt, 3);
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("t5_x", x, 32'h161E_255A);

        // 6a: short low glitch with data low must not look like a start bit
        ps2_data = 1'b0;
        wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(3);
        ps2_clk = 1'b1;
        wait_clk(20);
        ps2_data = 1'b1;
        wait_clk(20);
        send_frame(8'h3D, 1'b0, 1'b1);
        chk("t6_glitch_x", x, 32'h1E25_5A3D);

        // 6b: reset mid-frame drops the partial byte
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        run_chk = 1'b0;
        rst_n = 1'b0;
        wait_clk(3);
        chk("t6_rst_x", x, 32'h0);
        chk("t6_rst_flag", {31'b0, flag}, 32'h0);
        chk("t6_rst_cv", {31'b0, code_valid}, 32'h0);
        chk("t6_rst_fe", {31'b0, frame_err}, 32'h0);
        expq.delete();
        mx = '0; mflag = 1'b0; mbrk = 1'b0;
        cur_x = '0; cur_flag = 1'b0;
        ps2_data = 1'b1;
        rst_n = 1'b1;
        wait_clk(20);
        run_chk = 1'b1;
        send_frame(8'h45, 1'b0, 1'b1);
        chk("t6_after_x", x, 32'h0000_0045);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
